fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the tiny CPU. It drives a word-addressed synchronous instruction memory with fixed one-cycle read latency. Fetched words are held in a 2-entry buffer and presented, together with their PC, to the decode stage over a valid/ready handshake. Branch redirects come back from execute.

## Interface
- ADDR_W, 8, PC / instruction memory address width
- INSTR_W, 16, instruction word width
- RESET_PC, 0, first fetch address after reset
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_rd  out  1  read strobe to instruction memory
- imem_addr  out  ADDR_W  read address, equals the PC register
- imem_rdata  in  INSTR_W  read data, valid exactly one cycle after imem_rd
- instr_valid  out  1  buffer head holds a valid instruction
- instr  out  INSTR_W  instruction at buffer head
- instr_pc  out  ADDR_W  address of instr
- instr_ready  in  1  decode accepts the head this cycle
- br_taken  in  1  one-cycle redirect request
- br_target  in  ADDR_W  redirect address
- fetch_cnt  out  16  issued-fetch count (only with FETCH_PERF_EN)

Clock and reset are one clock with an asynchronous, active-high reset. They are named clk and rst.

## Operation
- **State**
  - PC register, reset RESET_PC.
  - inflight flag: a read was issued last cycle.
  - 2-entry FIFO of {instr, pc}.
  - count 0..2.
- **Pop.** pop = instr_valid & instr_ready. instr_valid = (count != 0).
- **Issue rule.** imem_rd = !br_taken & (count + inflight - pop < 2).
  - The buffer never overflows.
  - Steady state with instr_ready=1 gives one instruction per cycle.
- **On issue**
  - PC <= PC + 1, modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
  - inflight <= 1, and the issued address is retained for tagging.
- **Capture.** When inflight=1 and no kill applies, {imem_rdata, issued addr} is written to the FIFO tail at the clock edge.
- **Redirect (br_taken=1)** has priority over everything:
  - FIFO flushed and count <= 0.
  - A response arriving next cycle is discarded.
  - PC <= br_target.
  - imem_rd=0 in the redirect cycle.
  - A pop in the same cycle still counts as accepted by decode.
- **Simultaneous pop and capture** with count=2: count stays 2, the head advances, and the new entry is written to the freed slot.
- **No instr_ready.** Buffer contents and outputs hold stable while instr_valid=1 and instr_ready=0.

## Timing
- **Reset values:**
  - imem_rd=0, imem_addr=RESET_PC
  - instr_valid=0, instr=0, instr_pc=0
  - fetch_cnt=0
  - inflight=0, count=0
- **After reset deassertion:**
  - Cycle 0: imem_rd=1, addr RESET_PC.
  - Cycle 1: imem_rdata valid.
  - Cycle 2: instr_valid=1 with instr_pc=RESET_PC.
- **Redirect at cycle N:**
  - instr_valid=0 in N+1 and N+2.
  - Target issued in N+1.
  - Target instruction valid at N+3.
- **Back-to-back redirects:** the later one wins, and the timing restarts from it.
- **Reset asserted mid-operation:**
  - All state clears immediately (asynchronous).
  - Any in-flight response is ignored.
  - Behaviour after deassertion is identical to a cold start.

## Configuration
- **FETCH_PERF_EN defined:**
  - Port fetch_cnt exists.
  - The 16-bit counter increments on every cycle with imem_rd=1 and wraps 0xFFFF -> 0.
  - It is cleared only by rst; redirects do not clear it.
- **FETCH_PERF_EN undefined:** the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Cold start.** Memory word at address i = 0x1000+i, instr_ready=1 constantly, release rst:
  - instr_valid rises at cycle 2.
  - instr/instr_pc sequence is 0x1000/0, 0x1001/1, ... with one per cycle and no bubbles.
- **Backpressure.** Drop instr_ready for 5 cycles while streaming:
  - instr holds stable.
  - imem_rd stops once count+inflight reach 2.
  - No word is lost or duplicated on resume.
- **Redirect.** br_taken=1 with br_target=0x40 while 2 entries are buffered and a read is in flight:
  - instr_valid=0 for 2 cycles.
  - Next instruction has instr_pc=0x40.
  - The in-flight word never appears.
- **PC wrap.** RESET_PC=0xFE, ADDR_W=8: instr_pc sequence is 0xFE, 0xFF, 0x00, 0x01.
- **Reset mid-stream.** Assert rst for 1 cycle while count=2 and inflight=1:
  - Outputs go to reset values asynchronously.
  - The restart sequence matches cold start.
- **Perf counter (FETCH_PERF_EN).** 10 issues, then a redirect, then 3 issues: fetch_cnt=13.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory read port, decode handshake and branch redirect.
// The fetch unit uses the master modport; memory, decode and execute sit on the slave side.
interface fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               imem_rd;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;
    logic               br_taken;
    logic [ADDR_W-1:0]  br_target;

    modport master (
        output imem_rd, imem_addr,
        input  imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        input  br_taken, br_target
    );

    modport slave (
        input  imem_rd, imem_addr,
        output imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        output br_taken, br_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one-cycle-latency imem reads into a 2-entry {instr, pc} buffer for decode.
// Latency: first instruction valid 2 cycles after issue. Backpressure: stops issuing once
// buffered + in-flight words would exceed 2. Optional issue counter: define FETCH_PERF_EN.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]  fetch_cnt
`endif
);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  issued_pc;
    logic               inflight;
    logic [1:0]         count;
    logic               rd_ptr;
    logic               wr_ptr;
    logic [INSTR_W-1:0] buf_instr [2];
    logic [ADDR_W-1:0]  buf_pc    [2];

    logic pop;
    logic capture;
    logic issue;

    // Issue only if the word can be guaranteed a slot once it returns.
    always_comb begin
        pop     = (count != 2'd0) && bus.instr_ready;
        capture = inflight && !bus.br_taken;
        issue   = !rst && !bus.br_taken &&
                  (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
    end

    assign bus.imem_rd     = issue;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = (count != 2'd0);
    assign bus.instr       = buf_instr[rd_ptr];
    assign bus.instr_pc    = buf_pc[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            issued_pc <= '0;
            inflight  <= 1'b0;
            count     <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else begin
            inflight <= issue;
            if (bus.br_taken) begin
                // The flush also drops the word returning this cycle.
                pc     <= bus.br_target;
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (issue) begin
                    pc        <= pc + 1'b1;
                    issued_pc <= pc;
                end
                if (capture) begin
                    buf_instr[wr_ptr] <= bus.imem_rdata;
                    buf_pc[wr_ptr]    <= issued_pc;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                unique case ({capture, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= 16'd0;
        end else if (issue) begin
            fetch_cnt <= fetch_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model word[a] = 0x1000+a, in-order PC scoreboard in a monitor,
// and per-scenario timing checks with randomized ready/redirect traffic.
module tb_fetch_unit;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt;
`endif

    fetch_unit #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .RESET_PC(8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt(fetch_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [INSTR_W-1:0] mem [256];

    // Synchronous memory with one-cycle latency; junk on the bus when not reading.
    always @(posedge clk) begin
        if (bus.imem_rd === 1'b1) bus.imem_rdata <= mem[bus.imem_addr];
        else                      bus.imem_rdata <= 16'($urandom);
    end

    // Scoreboard: decode must see consecutive addresses from the last reset/redirect.
    logic [ADDR_W-1:0]  exp_pc;
    int                 n_acc = 0;
    int                 n_issue = 0;
    logic               hold_vld = 1'b0;
    logic [INSTR_W-1:0] hold_instr;
    logic [ADDR_W-1:0]  hold_pc;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc   = 8'h00;
            hold_vld = 1'b0;
            n_issue  = 0;
        end else begin
            if (hold_vld) begin
                checks++;
                if (bus.instr_valid !== 1'b1 || bus.instr !== hold_instr || bus.instr_pc !== hold_pc) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%b %h/%h want v=1 %h/%h",
                             bus.instr_valid, bus.instr, bus.instr_pc, hold_instr, hold_pc);
                end
            end
            if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
                checks++;
                if (bus.instr_pc !== exp_pc || bus.instr !== mem[exp_pc]) begin
                    errors++;
                    $display("FAIL stream_order: got %h/%h want %h/%h",
                             bus.instr, bus.instr_pc, mem[exp_pc], exp_pc);
                end
                exp_pc = exp_pc + 8'd1;
                n_acc++;
            end
            hold_vld   = (bus.instr_valid === 1'b1) && !bus.instr_ready && !bus.br_taken;
            hold_instr = bus.instr;
            hold_pc    = bus.instr_pc;
            if (bus.br_taken) begin
                exp_pc = bus.br_target;
                checks++;
                if (bus.imem_rd !== 1'b0) begin
                    errors++;
                    $display("FAIL redirect_no_issue: got imem_rd=%b want 0", bus.imem_rd);
                end
            end
`ifdef FETCH_PERF_EN
            checks++;
            if (fetch_cnt !== 16'(n_issue)) begin
                errors++;
                $display("FAIL perf_track: got fetch_cnt=%0d want %0d", fetch_cnt, n_issue);
            end
`endif
            if (bus.imem_rd === 1'b1) n_issue++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.br_taken = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Called right at cycle 0 after reset release, with instr_ready=1.
    task automatic check_startup(input string tag);
        @(negedge clk);
        checks++;
        if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'h00 || bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_cycle0: got rd=%b addr=%h v=%b want rd=1 addr=00 v=0",
                     tag, bus.imem_rd, bus.imem_addr, bus.instr_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_cycle1: got v=%b want 0", tag, bus.instr_valid);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(k) || bus.instr !== 16'h1000 + 16'(k)) begin
                errors++;
                $display("FAIL %s_stream%0d: got v=%b %h/%h want v=1 %h/%h", tag, k,
                         bus.instr_valid, bus.instr, bus.instr_pc, 16'h1000 + 16'(k), 8'(k));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.instr_ready = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_target = '0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.imem_rd !== 1'b0 || bus.imem_addr !== 8'h00 || bus.instr_valid !== 1'b0 ||
            bus.instr !== 16'h0 || bus.instr_pc !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: got rd=%b addr=%h v=%b %h/%h want 0 00 0 0000/00",
                     bus.imem_rd, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (fetch_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d want 0", fetch_cnt);
        end
`endif
    endtask

    task automatic test_cold_start();
        @(posedge clk); #1;
        bus.instr_ready = 1'b1;
        rst = 1'b0;
        check_startup("cold");
    endtask

    task automatic test_backpressure();
        logic [ADDR_W-1:0] stall_pc;
        int acc0;
        @(posedge clk); #1;
        bus.instr_ready = 1'b0;
        @(negedge clk);
        stall_pc = bus.instr_pc;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (bus.imem_rd !== 1'b0 || bus.instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_cycle%0d: got rd=%b v=%b want rd=0 v=1", k, bus.imem_rd, bus.instr_valid);
            end
        end
        @(posedge clk); #1;
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== stall_pc + 8'(k)) begin
                errors++;
                $display("FAIL resume%0d: got v=%b pc=%h want v=1 pc=%h", k,
                         bus.instr_valid, bus.instr_pc, stall_pc + 8'(k));
            end
        end
        acc0 = n_acc;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            bus.instr_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (n_acc - acc0 < 20) begin
            errors++;
            $display("FAIL random_ready_progress: got %0d accepted want >=20", n_acc - acc0);
        end
    endtask

    task automatic redirect_and_check(input string tag, input logic [ADDR_W-1:0] tgt, input logic rdy);
        @(posedge clk); #1;
        bus.br_taken = 1'b1;
        bus.br_target = tgt;
        bus.instr_ready = rdy;
        @(posedge clk); #1;
        bus.br_taken = 1'b0;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_rd !== 1'b1 || bus.imem_addr !== tgt) begin
            errors++;
            $display("FAIL %s_n1: got v=%b rd=%b addr=%h want v=0 rd=1 addr=%h",
                     tag, bus.instr_valid, bus.imem_rd, bus.imem_addr, tgt);
        end
        @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_n2: got v=%b want 0", tag, bus.instr_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== tgt || bus.instr !== mem[tgt]) begin
            errors++;
            $display("FAIL %s_n3: got v=%b %h/%h want v=1 %h/%h",
                     tag, bus.instr_valid, bus.instr, bus.instr_pc, mem[tgt], tgt);
        end
    endtask

    task automatic test_redirect();
        redirect_and_check("redir_stall", 8'h40, 1'b0);
        repeat (3) @(posedge clk);
        redirect_and_check("redir_pop", 8'h10, 1'b1);
    endtask

    task automatic test_pc_wrap();
        logic [ADDR_W-1:0] want;
        redirect_and_check("wrap", 8'hFE, 1'b1);
        for (int k = 1; k < 4; k++) begin
            want = 8'hFE + 8'(k);
            @(negedge clk);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== want) begin
                errors++;
                $display("FAIL wrap_seq%0d: got v=%b pc=%h want v=1 pc=%h", k, bus.instr_valid, bus.instr_pc, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        bus.br_taken = 1'b1;
        bus.br_target = 8'h80;
        @(posedge clk); #1;
        bus.br_target = 8'h20;
        @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_rd !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got v=%b rd=%b want 0 0", bus.instr_valid, bus.imem_rd);
        end
        redirect_tail_check();
    endtask

    task automatic redirect_tail_check();
        @(posedge clk); #1;
        bus.br_taken = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 8'h20 || bus.imem_rd !== 1'b1) begin
            errors++;
            $display("FAIL b2b_issue: got v=%b rd=%b addr=%h want v=0 rd=1 addr=20",
                     bus.instr_valid, bus.imem_rd, bus.imem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h20) begin
            errors++;
            $display("FAIL b2b_target: got v=%b pc=%h want v=1 pc=20", bus.instr_valid, bus.instr_pc);
        end
    endtask

    task automatic test_reset_midstream();
        @(posedge clk); #1;
        bus.instr_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.imem_rd !== 1'b0 || bus.imem_addr !== 8'h00 || bus.instr_valid !== 1'b0 ||
            bus.instr !== 16'h0 || bus.instr_pc !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got rd=%b addr=%h v=%b %h/%h want 0 00 0 0000/00",
                     bus.imem_rd, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc);
        end
        bus.instr_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_startup("warm");
    endtask

    task automatic test_random_redirects();
        int acc0;
        acc0 = n_acc;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.br_taken    = ($urandom_range(0, 15) == 0);
            bus.br_target   = 8'($urandom);
        end
        @(posedge clk); #1;
        bus.br_taken = 1'b0;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (n_acc - acc0 < 60) begin
            errors++;
            $display("FAIL random_redirect_progress: got %0d accepted want >=60", n_acc - acc0);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        bus.instr_ready = 1'b1;
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        bus.br_taken = 1'b1;
        bus.br_target = 8'h30;
        @(posedge clk); #1;
        bus.br_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.br_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (fetch_cnt !== 16'd13) begin
            errors++;
            $display("FAIL perf_count: got %0d want 13", fetch_cnt);
        end
        @(posedge clk); #1;
        bus.br_taken = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        test_reset();
        test_cold_start();
        test_backpressure();
        test_redirect();
        test_pc_wrap();
        test_back_to_back();
        test_reset_midstream();
        test_random_redirects();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
